// File: rtl/gf256_pkg.sv
// rtl/gf256_pkg.sv - shared GF(2^8) constants, FSM states and latency helper
package gf256_pkg;

    localparam logic [8:0] GF_POLY = 9'h11D;
    localparam logic [7:0] GF_ONE  = 8'h01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQR  = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } pow_state_t;

    // One squaring and one (possibly trivial) multiply per exponent bit.
    function automatic int pow_lat(input int exp_w);
        return 2 * exp_w;
    endfunction

endpackage

// File: rtl/gf256_mul.sv
// rtl/gf256_mul.sv - combinational GF(2^8) multiplier, reduction polynomial 0x11D
module gf256_mul
    import gf256_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);

    logic [7:0] acc;
    logic [7:0] sh;

    // Shift-and-add with reduction folded into each doubling of a.
    always_comb begin
        acc = 8'h00;
        sh  = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) begin
                acc = acc ^ sh;
            end
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? GF_POLY[7:0] : 8'h00);
        end
    end

    assign p = acc;

endmodule

// File: rtl/gf256_pow_seq.sv
// rtl/gf256_pow_seq.sv - sequenced GF(2^8) exponentiation A^E by square-and-multiply
module gf256_pow_seq
    import gf256_pkg::*;
#(
    parameter int EXP_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [EXP_W-1:0] in_e,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_x,
    output logic             busy
);

    localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(EXP_W - 1);

    pow_state_t       state;
    logic [7:0]       a_q;
    logic [EXP_W-1:0] e_q;
    logic [7:0]       r;
    logic [IDX_W-1:0] idx;
    logic [7:0]       op_b;
    logic [7:0]       prod;

    // MUL always multiplies (by A or by one) so latency never depends on E.
    always_comb begin
        op_b = r;
        if (state == MUL) begin
            op_b = e_q[idx] ? a_q : GF_ONE;
        end
    end

    gf256_mul u_mul (
        .a (r),
        .b (op_b),
        .p (prod)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            a_q       <= 8'h00;
            e_q       <= '0;
            r         <= GF_ONE;
            idx       <= IDX_MAX;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_x     <= GF_ONE;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= in_a;
                        e_q      <= in_e;
                        r        <= GF_ONE;
                        idx      <= IDX_MAX;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SQR;
                    end
                end
                SQR: begin
                    r     <= prod;
                    state <= MUL;
                end
                MUL: begin
                    r <= prod;
                    if (idx == '0) begin
                        out_x     <= prod;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx   <= idx - 1'b1;
                        state <= SQR;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
